// File: rtl/special_register_pkg.sv
// Shared definitions for the special-purpose register bank:
// register indices and the stack-operation encoding.
package special_register_pkg;

  localparam int ZERO          = 0;
  localparam int ADDRESS       = 1;
  localparam int BASE          = 2;
  localparam int INDEX         = 3;
  localparam int STACK_POINTER = 4;
  localparam int BASE_POINTER  = 5;
  localparam int DATA          = 6;

  typedef enum logic [2:0] {
    NONE,
    LOAD,
    INC,
    DEC,
    HOLD
  } stack_op_e;

  // Priority: load beats push/pop; push with pop holds.
  function automatic stack_op_e stack_op(
    input logic load,
    input logic push,
    input logic pop
  );
    stack_op_e op;
    op = NONE;
    unique case (1'b1)
      load:                  op = LOAD;
      (!load && push && pop):  op = HOLD;
      (!load && push && !pop): op = INC;
      (!load && pop && !push): op = DEC;
      default:               op = NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with limit checks and sticky
// overflow/underflow flags; exposes its next state.
module stack_pointer_unit
  import special_register_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] STACK_BASE  = '0,
  parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clearFlags,
  output logic [DATA_WIDTH-1:0] sp,
  output logic [DATA_WIDTH-1:0] spNext,
  output logic                  overflow,
  output logic                  underflow
);

  stack_op_e op;
  logic      atLimit;
  logic      atBase;
  logic      overflowSet;
  logic      underflowSet;
  logic      overflowNext;
  logic      underflowNext;

  assign op      = stack_op(load, push, pop);
  assign atLimit = (sp >= STACK_LIMIT);
  assign atBase  = (sp <= STACK_BASE);

  // Next pointer value; a rejected step raises a flag instead.
  always_comb begin
    spNext       = sp;
    overflowSet  = 1'b0;
    underflowSet = 1'b0;
    unique case (op)
      LOAD: spNext = loadData;
      INC: begin
        if (!atLimit) spNext = sp + DATA_WIDTH'(1);
        else          overflowSet = 1'b1;
      end
      DEC: begin
        if (!atBase) spNext = sp - DATA_WIDTH'(1);
        else         underflowSet = 1'b1;
      end
      HOLD:    spNext = sp;
      NONE:    spNext = sp;
      default: spNext = sp;
    endcase
  end

  // Sticky flags: a new event wins over a same-cycle clear.
  always_comb begin
    overflowNext  = (overflow && !clearFlags) || overflowSet;
    underflowNext = (underflow && !clearFlags) || underflowSet;
  end

  // Pointer and flag state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp        <= STACK_BASE;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= spNext;
      overflow  <= overflowNext;
      underflow <= underflowNext;
    end
  end

endmodule

// File: rtl/special_register_bank.sv
// Special-purpose register bank: zero register, plain storage,
// stack pointer unit and a registered write-through read port.
module special_register_bank
  import special_register_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] STACK_BASE  = 16'h0000,
  parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] readData,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clearFlags,
  output logic [DATA_WIDTH-1:0] stackPointer,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] SP_ADDR =
    ADDR_WIDTH'(STACK_POINTER);

  logic [DATA_WIDTH-1:0] nxt [REG_COUNT];
  logic [DATA_WIDTH-1:0] spNext;
  logic [DATA_WIDTH-1:0] rdNext;
  logic                  spLoad;

  assign spLoad = writeEnable && (writeAddress == SP_ADDR);

  stack_pointer_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .STACK_BASE (STACK_BASE),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_sp (
    .clock     (clock),
    .reset     (reset),
    .load      (spLoad),
    .loadData  (writeData),
    .push      (push),
    .pop       (pop),
    .clearFlags(clearFlags),
    .sp        (stackPointer),
    .spNext    (spNext),
    .overflow  (overflow),
    .underflow (underflow)
  );

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if (i == ZERO) begin : g_zero
      assign nxt[i] = '0;
    end else if (i == STACK_POINTER) begin : g_sp
      assign nxt[i] = spNext;
    end else begin : g_plain
      logic [DATA_WIDTH-1:0] q;
      logic                  hit;
      assign hit = writeEnable &&
                   (writeAddress == ADDR_WIDTH'(i));
      assign nxt[i] = hit ? writeData : q;
      // Plain storage: changes only on an addressed write.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)   q <= '0;
        else if (hit) q <= writeData;
      end
    end
  end

  // Read mux over next-state values; out-of-range reads give 0.
  always_comb begin
    rdNext = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (readAddress == ADDR_WIDTH'(i)) rdNext = nxt[i];
    end
  end

  // Registered read port; idle cycles return 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          readData <= '0;
    else if (readEnable) readData <= rdNext;
    else                 readData <= '0;
  end

endmodule

// File: tb/tb_special_register_bank.sv
// Bench for special_register_bank: directed plan plus random
// traffic on two instances (default limit and limit 2).
module tb_special_register_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  ra = '0;
  logic        we = 1'b0;
  logic [3:0]  wa = '0;
  logic [15:0] wd = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] rd0, rd1, sp0, sp1;
  logic        ov0, ov1, un0, un1;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_mem [2][8];
  logic [15:0] m_sp [2];
  logic        m_ov [2];
  logic        m_un [2];
  logic [15:0] m_rd [2];
  logic [15:0] lim [2];

  always #5 clock = ~clock;

  special_register_bank dut0 (
    .clock(clock), .reset(reset),
    .readEnable(re), .readAddress(ra), .readData(rd0),
    .writeEnable(we), .writeAddress(wa), .writeData(wd),
    .push(push), .pop(pop), .clearFlags(clr),
    .stackPointer(sp0), .overflow(ov0), .underflow(un0)
  );

  special_register_bank #(.STACK_LIMIT(16'h0002)) dut1 (
    .clock(clock), .reset(reset),
    .readEnable(re), .readAddress(ra), .readData(rd1),
    .writeEnable(we), .writeAddress(wa), .writeData(wd),
    .push(push), .pop(pop), .clearFlags(clr),
    .stackPointer(sp1), .overflow(ov1), .underflow(un1)
  );

  task automatic check(string tag, logic [15:0] obs,
                       logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".rd0"}, rd0, m_rd[0]);
    check({tag, ".sp0"}, sp0, m_sp[0]);
    check({tag, ".ov0"}, 16'(ov0), 16'(m_ov[0]));
    check({tag, ".un0"}, 16'(un0), 16'(m_un[0]));
    check({tag, ".rd1"}, rd1, m_rd[1]);
    check({tag, ".sp1"}, sp1, m_sp[1]);
    check({tag, ".ov1"}, 16'(ov1), 16'(m_ov[1]));
    check({tag, ".un1"}, 16'(un1), 16'(m_un[1]));
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 8; r++) m_mem[m][r] = '0;
      m_sp[m] = 16'h0000;
      m_ov[m] = 1'b0;
      m_un[m] = 1'b0;
      m_rd[m] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [15:0] nsp;
      logic        nov;
      logic        nun;
      nsp = m_sp[m];
      nov = m_ov[m] && !clr;
      nun = m_un[m] && !clr;
      if (we && wa == 4'd4) nsp = wd;
      else if (push && !pop) begin
        if (m_sp[m] < lim[m]) nsp = m_sp[m] + 16'd1;
        else nov = 1'b1;
      end else if (pop && !push) begin
        if (m_sp[m] > 16'h0000) nsp = m_sp[m] - 16'd1;
        else nun = 1'b1;
      end
      if (we && wa < 4'd8 && wa != 4'd0 && wa != 4'd4)
        m_mem[m][wa[2:0]] = wd;
      m_sp[m] = nsp;
      m_ov[m] = nov;
      m_un[m] = nun;
      if (!re || ra >= 4'd8 || ra == 4'd0) m_rd[m] = '0;
      else if (ra == 4'd4) m_rd[m] = nsp;
      else m_rd[m] = m_mem[m][ra[2:0]];
    end
  endtask

  task automatic idle();
    re = 0; we = 0; push = 0; pop = 0; clr = 0;
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    lim[0] = 16'hFFFF;
    lim[1] = 16'h0002;
    model_reset();
    idle();
    #22;
    check_all("reset");
    @(posedge clock);
    #1 reset = 1'b1;

    for (int a = 0; a < 8; a++) begin
      idle(); re = 1; ra = 4'(a);
      step("rd_reset");
    end

    idle(); we = 1; wa = 4'd1; wd = 16'h1234; step("wr1");
    idle(); we = 1; wa = 4'd0; wd = 16'hBEEF; step("wr0");
    idle(); re = 1; ra = 4'd1; step("rd1");
    check("rd1_val", rd0, 16'h1234);
    idle(); re = 1; ra = 4'd0; step("rd0");
    check("rd0_val", rd0, 16'h0000);

    repeat (3) begin idle(); push = 1; step("push"); end
    check("push3_sp", sp0, 16'h0003);
    check("lim_sp", sp1, 16'h0002);
    check("lim_ov", 16'(ov1), 16'h0001);
    repeat (4) begin idle(); pop = 1; step("pop"); end
    check("pop4_sp", sp0, 16'h0000);
    check("pop4_un", 16'(un0), 16'h0001);
    idle(); clr = 1; step("clr");
    check("clr_un", 16'(un0), 16'h0000);

    repeat (3) begin idle(); push = 1; step("push_b"); end
    idle(); push = 1; clr = 1; step("clr_set");
    check("clr_set_ov", 16'(ov1), 16'h0001);

    idle(); we = 1; wa = 4'd4; wd = 16'h0040;
    push = 1; re = 1; ra = 4'd4; step("ld_sp");
    check("ld_sp_val", sp0, 16'h0040);
    check("ld_rd_val", rd0, 16'h0040);

    repeat (400) begin
      idle();
      re   = 1'($urandom_range(0, 1));
      ra   = 4'($urandom_range(0, 15));
      we   = ($urandom_range(0, 3) == 0);
      wa   = 4'($urandom_range(0, 15));
      wd   = (wa == 4'd4 && $urandom_range(0, 1) == 1)
             ? 16'($urandom_range(0, 4))
             : 16'($urandom);
      push = 1'($urandom_range(0, 1));
      pop  = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    idle(); clr = 1; we = 1; wa = 4'd4; wd = 16'h0002;
    step("pre_burst");
    repeat (3) begin
      idle(); push = 1; re = 1; ra = 4'd4; step("burst");
    end
    check("burst_sp", sp0, 16'h0005);
    idle(); push = 1; re = 1; ra = 4'd4;
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_sp", sp0, 16'h0000);
    #1 reset = 1'b1;
    idle(); push = 1; step("post_rst");
    check("post_rst_sp", sp0, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
